// File: rtl/hazard_stall_ctrl.sv
// Pipeline hazard controller: load-use stall, multi-cycle mul/div sequencing,
// and branch/exception flushes for the 5-stage core.
module hazard_stall_ctrl #(
    parameter int DIV_LAT = 32,
    parameter int MUL_LAT = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [4:0] ID_rs,
    input  logic [4:0] ID_rt,
    input  logic       ID_ReadRs,
    input  logic       ID_ReadRt,
    input  logic [4:0] EXE_Dst,
    input  logic       EXE_IsLoad,
    input  logic       EXE_IsDiv,
    input  logic       EXE_IsMul,
    input  logic       EXE_BranchTaken,
    input  logic       MEM_ExcFlush,
    output logic       PC_Wr,
    output logic       IF_ID_Wr,
    output logic       ID_EXE_Wr,
    output logic       EXE_MEM_Wr,
    output logic       IF_ID_Flush,
    output logic       ID_EXE_Flush,
    output logic       EXE_MEM_Flush,
    output logic       MulDiv_Start,
    output logic       MulDiv_Busy
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // The start cycle is one stall cycle and the cnt==0 BUSY cycle is another.
    localparam logic [5:0] DIV_INIT = 6'(DIV_LAT - 2);
    localparam logic [5:0] MUL_INIT = 6'(MUL_LAT - 2);

    state_t     r_state;
    state_t     w_state_nxt;
    logic [5:0] r_cnt;
    logic [5:0] w_cnt_nxt;
    logic       w_md_req;
    logic       w_load_use;

    assign w_md_req   = EXE_IsDiv | EXE_IsMul;
    assign w_load_use = EXE_IsLoad && (EXE_Dst != 5'd0) &&
                        ((ID_ReadRs && (ID_rs == EXE_Dst)) ||
                         (ID_ReadRt && (ID_rt == EXE_Dst)));

    // State and countdown registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_cnt   <= 6'd0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // Next-state and counter logic; an exception aborts any in-flight op.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        if (MEM_ExcFlush) begin
            w_state_nxt = ST_IDLE;
            w_cnt_nxt   = 6'd0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_md_req) begin
                        w_state_nxt = ST_BUSY;
                        w_cnt_nxt   = EXE_IsDiv ? DIV_INIT : MUL_INIT;
                    end else begin
                        w_state_nxt = ST_IDLE;
                    end
                end
                ST_BUSY: begin
                    if (r_cnt == 6'd0) begin
                        w_state_nxt = ST_DONE;
                    end else begin
                        w_cnt_nxt = r_cnt - 6'd1;
                    end
                end
                ST_DONE: begin
                    w_state_nxt = ST_IDLE;
                end
                default: begin
                    w_state_nxt = ST_IDLE;
                    w_cnt_nxt   = 6'd0;
                end
            endcase
        end
    end

    // Pipeline control outputs, first matching rule wins.
    always_comb begin
        PC_Wr         = 1'b1;
        IF_ID_Wr      = 1'b1;
        ID_EXE_Wr     = 1'b1;
        EXE_MEM_Wr    = 1'b1;
        IF_ID_Flush   = 1'b0;
        ID_EXE_Flush  = 1'b0;
        EXE_MEM_Flush = 1'b0;
        MulDiv_Start  = 1'b0;
        MulDiv_Busy   = 1'b0;
        if (MEM_ExcFlush) begin
            IF_ID_Flush   = 1'b1;
            ID_EXE_Flush  = 1'b1;
            EXE_MEM_Flush = 1'b1;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_md_req) begin
                        MulDiv_Start  = 1'b1;
                        PC_Wr         = 1'b0;
                        IF_ID_Wr      = 1'b0;
                        ID_EXE_Wr     = 1'b0;
                        EXE_MEM_Flush = 1'b1;
                    end else if (EXE_BranchTaken) begin
                        IF_ID_Flush  = 1'b1;
                        ID_EXE_Flush = 1'b1;
                    end else if (w_load_use) begin
                        PC_Wr        = 1'b0;
                        IF_ID_Wr     = 1'b0;
                        ID_EXE_Flush = 1'b1;
                    end else begin
                        PC_Wr = 1'b1;
                    end
                end
                ST_BUSY: begin
                    // Busy drops in the very cycle reset is sampled.
                    MulDiv_Busy   = ~rst;
                    PC_Wr         = 1'b0;
                    IF_ID_Wr      = 1'b0;
                    ID_EXE_Wr     = 1'b0;
                    EXE_MEM_Flush = 1'b1;
                end
                ST_DONE: begin
                    if (EXE_BranchTaken) begin
                        IF_ID_Flush  = 1'b1;
                        ID_EXE_Flush = 1'b1;
                    end else if (w_load_use) begin
                        PC_Wr        = 1'b0;
                        IF_ID_Wr     = 1'b0;
                        ID_EXE_Flush = 1'b1;
                    end else begin
                        PC_Wr = 1'b1;
                    end
                end
                default: begin
                    PC_Wr = 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Scoreboard bench for hazard_stall_ctrl: stimulus pushes expected control
// vectors, a negedge monitor pops and compares them.
module tb_hazard_stall_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic [4:0] ID_rs, ID_rt, EXE_Dst;
    logic       ID_ReadRs, ID_ReadRt, EXE_IsLoad, EXE_IsDiv, EXE_IsMul;
    logic       EXE_BranchTaken, MEM_ExcFlush;
    logic       PC_Wr, IF_ID_Wr, ID_EXE_Wr, EXE_MEM_Wr;
    logic       IF_ID_Flush, ID_EXE_Flush, EXE_MEM_Flush, MulDiv_Start, MulDiv_Busy;

    // {PC_Wr, IF_ID_Wr, ID_EXE_Wr, EXE_MEM_Wr, IF_ID_Fl, ID_EXE_Fl, EXE_MEM_Fl, Start, Busy}
    localparam logic [8:0] V_NORM  = 9'b1111_000_00;
    localparam logic [8:0] V_START = 9'b0001_001_10;
    localparam logic [8:0] V_BUSY  = 9'b0001_001_01;
    localparam logic [8:0] V_EXC   = 9'b1111_111_00;
    localparam logic [8:0] V_BR    = 9'b1111_110_00;
    localparam logic [8:0] V_LU    = 9'b0011_010_00;

    int checks = 0;
    int failures = 0;

    logic [9:0] exp_q[$];
    string      name_q[$];

    always #5 clk = ~clk;

    hazard_stall_ctrl #(.DIV_LAT(32), .MUL_LAT(2)) dut (
        .clk(clk), .rst(rst),
        .ID_rs(ID_rs), .ID_rt(ID_rt), .ID_ReadRs(ID_ReadRs), .ID_ReadRt(ID_ReadRt),
        .EXE_Dst(EXE_Dst), .EXE_IsLoad(EXE_IsLoad), .EXE_IsDiv(EXE_IsDiv),
        .EXE_IsMul(EXE_IsMul), .EXE_BranchTaken(EXE_BranchTaken),
        .MEM_ExcFlush(MEM_ExcFlush),
        .PC_Wr(PC_Wr), .IF_ID_Wr(IF_ID_Wr), .ID_EXE_Wr(ID_EXE_Wr),
        .EXE_MEM_Wr(EXE_MEM_Wr), .IF_ID_Flush(IF_ID_Flush),
        .ID_EXE_Flush(ID_EXE_Flush), .EXE_MEM_Flush(EXE_MEM_Flush),
        .MulDiv_Start(MulDiv_Start), .MulDiv_Busy(MulDiv_Busy)
    );

    // Monitor: the control vector is presented every cycle; compare mid-cycle.
    always @(negedge clk) begin
        logic [9:0] e;
        logic [8:0] act;
        string      nm;
        if (exp_q.size() > 0) begin
            e   = exp_q.pop_front();
            nm  = name_q.pop_front();
            act = {PC_Wr, IF_ID_Wr, ID_EXE_Wr, EXE_MEM_Wr, IF_ID_Flush,
                   ID_EXE_Flush, EXE_MEM_Flush, MulDiv_Start, MulDiv_Busy};
            if (e[9]) begin
                checks++;
                if (act !== e[8:0]) begin
                    failures++;
                    $display("FAIL %s: got %b expected %b (t=%0t)", nm, act, e[8:0], $time);
                end
            end
        end
    end

    task automatic clear_inputs();
        ID_rs = 5'd0; ID_rt = 5'd0; EXE_Dst = 5'd0;
        ID_ReadRs = 1'b0; ID_ReadRt = 1'b0; EXE_IsLoad = 1'b0;
        EXE_IsDiv = 1'b0; EXE_IsMul = 1'b0;
        EXE_BranchTaken = 1'b0; MEM_ExcFlush = 1'b0;
    endtask

    // Inputs are already set; queue this cycle's expectation, then advance.
    task automatic drive(input logic [8:0] e, input logic chk, input string nm);
        exp_q.push_back({chk, e});
        name_q.push_back(nm);
        @(posedge clk);
        #1;
    endtask

    task automatic muldiv_seq(input logic d, input logic m, input int nbusy,
                              input logic br, input string tag);
        clear_inputs();
        EXE_IsDiv = d; EXE_IsMul = m;
        drive(V_START, 1'b1, {tag, "_start"});
        EXE_BranchTaken = br;
        for (int i = 0; i < nbusy; i++) drive(V_BUSY, 1'b1, {tag, "_busy"});
        // DONE: operation still in EXE, Start must stay low
        drive(br ? V_BR : V_NORM, 1'b1, {tag, "_done"});
        clear_inputs();
        drive(V_NORM, 1'b1, {tag, "_idle"});
    endtask

    initial begin
        rst = 1'b1;
        clear_inputs();
        @(posedge clk);
        #1;
        drive(V_NORM, 1'b0, "in_reset");
        rst = 1'b0;
        drive(V_NORM, 1'b1, "reset_idle");

        // Load-use: hit on rs, release, Dst=0, rs not read, hit on rt
        EXE_IsLoad = 1'b1; EXE_Dst = 5'd5; ID_rs = 5'd5; ID_ReadRs = 1'b1;
        drive(V_LU, 1'b1, "lu_rs");
        EXE_IsLoad = 1'b0;
        drive(V_NORM, 1'b1, "lu_release");
        EXE_IsLoad = 1'b1; EXE_Dst = 5'd0; ID_rs = 5'd0;
        drive(V_NORM, 1'b1, "lu_dst0");
        EXE_Dst = 5'd5; ID_rs = 5'd5; ID_ReadRs = 1'b0;
        drive(V_NORM, 1'b1, "lu_noread");
        ID_rt = 5'd7; EXE_Dst = 5'd7; ID_ReadRt = 1'b1;
        drive(V_LU, 1'b1, "lu_rt");
        clear_inputs();
        EXE_BranchTaken = 1'b1;
        drive(V_BR, 1'b1, "br_idle");

        muldiv_seq(1'b1, 1'b0, 31, 1'b0, "div");
        muldiv_seq(1'b0, 1'b1, 1, 1'b0, "mul");
        muldiv_seq(1'b1, 1'b1, 31, 1'b0, "divmul");
        muldiv_seq(1'b0, 1'b1, 1, 1'b1, "mulbr");
        muldiv_seq(1'b1, 1'b0, 31, 1'b1, "divbr");

        // Exception on BUSY cycle 10 of a divide
        clear_inputs();
        EXE_IsDiv = 1'b1;
        drive(V_START, 1'b1, "exc_start");
        for (int i = 0; i < 9; i++) drive(V_BUSY, 1'b1, "exc_busy");
        MEM_ExcFlush = 1'b1;
        drive(V_EXC, 1'b1, "exc_flush");
        clear_inputs();
        drive(V_NORM, 1'b1, "exc_idle");

        // Exception in IDLE beats a new divide: no Start, no BUSY afterwards
        EXE_IsDiv = 1'b1; MEM_ExcFlush = 1'b1;
        drive(V_EXC, 1'b1, "exc_nostart");
        clear_inputs();
        drive(V_NORM, 1'b1, "exc_nostart_idle");

        // Reset while BUSY with cnt=20 (11th BUSY cycle)
        EXE_IsDiv = 1'b1;
        drive(V_START, 1'b1, "rst_start");
        for (int i = 0; i < 10; i++) drive(V_BUSY, 1'b1, "rst_busy");
        rst = 1'b1;
        drive(V_NORM, 1'b0, "rst_mid");
        rst = 1'b0;
        clear_inputs();
        drive(V_NORM, 1'b1, "rst_idle");
        muldiv_seq(1'b1, 1'b0, 31, 1'b0, "div_after_rst");

        repeat (3) @(negedge clk);
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL drain: got %0d pending expected 0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
